// File: rtl/voice_mixer_tdm.sv
// Time-multiplexed multi-voice oscillator/mixer: one shared waveform/volume datapath swept over N_VOICES per sample_tick.
// Optional build macro VOICE_MIXER_NOISE_EN turns wave_sel=3 into a shared 16-bit LFSR noise source (otherwise silence).
module voice_mixer_tdm #(
  parameter int N_VOICES = 8,
  parameter int PHASE_W  = 24,
  parameter int VOL_W    = 8,
  parameter int OUT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_tick,
  input  logic [N_VOICES*PHASE_W-1:0]  phase_inc,
  input  logic [N_VOICES*2-1:0]        wave_sel,
  input  logic [N_VOICES*VOL_W-1:0]    volume,
  output logic signed [OUT_W-1:0]      out_sample,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int VIDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int ACC_W  = 16 + $clog2(N_VOICES) + 1;
  localparam int PROD_W = 16 + VOL_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32'sd32768);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAVE  = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_r;
  logic [VIDX_W-1:0]         voice_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic [PHASE_W-1:0]        phase_r [N_VOICES];
  logic [PHASE_W-1:0]        ph_r;
  logic [PHASE_W-1:0]        inc_r;
  logic [1:0]                sel_r;
  logic [VOL_W-1:0]          vol_r;
  logic signed [15:0]        wave_r;
  logic [15:0]               lfsr_r;

  logic [15:0]               p_s;
  logic [15:0]               tri_s;
  logic signed [15:0]        wave_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   scaled_s;

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI) begin
      sat16 = 16'sh7FFF;
    end else if (a < SAT_LO) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = a[15:0];
    end
  endfunction

  // Waveform generator: uses the latched (pre-increment) phase of the current voice
  always_comb begin
    p_s   = ph_r[PHASE_W-1 -: 16];
    tri_s = p_s[15] ? ~p_s : p_s;
    case (sel_r)
      2'd0:    wave_s = p_s[15] ? 16'sh8000 : 16'sh7FFF;
      2'd1:    wave_s = p_s ^ 16'h8000;
      2'd2:    wave_s = {tri_s[14:0], 1'b0} - 16'h8000;
`ifdef VOICE_MIXER_NOISE_EN
      2'd3:    wave_s = lfsr_r;
`else
      2'd3:    wave_s = 16'sd0;
`endif
      default: wave_s = 16'sd0;
    endcase
  end

  // Volume scaling: signed wave times unsigned volume, floor-shifted back to wave scale
  always_comb begin
    prod_s   = PROD_W'(wave_r) * PROD_W'($signed({1'b0, vol_r}));
    scaled_s = ACC_W'(prod_s >>> VOL_W);
  end

`ifdef VOICE_MIXER_NOISE_EN
  // Shared noise LFSR: advances only when a noise voice consumes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else if (state_r == S_WAVE && sel_r == 2'd3) begin
      lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
    end
  end
`else
  assign lfsr_r = 16'h0000;
`endif

  // Frame sequencer: LOAD/WAVE/SCALE per voice, then DONE publishes the clamped mix
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      voice_r    <= '0;
      acc_r      <= '0;
      ph_r       <= '0;
      inc_r      <= '0;
      sel_r      <= 2'd0;
      vol_r      <= '0;
      wave_r     <= 16'sd0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
        phase_r[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (sample_tick) begin
            voice_r <= '0;
            acc_r   <= '0;
            busy    <= 1'b1;
            state_r <= S_LOAD;
          end
        end
        S_LOAD: begin
          inc_r   <= phase_inc[voice_r*PHASE_W +: PHASE_W];
          sel_r   <= wave_sel[voice_r*2 +: 2];
          vol_r   <= volume[voice_r*VOL_W +: VOL_W];
          ph_r    <= phase_r[voice_r];
          state_r <= S_WAVE;
          if (sample_tick) overrun <= 1'b1;
        end
        S_WAVE: begin
          wave_r           <= wave_s;
          phase_r[voice_r] <= ph_r + inc_r;
          state_r          <= S_SCALE;
          if (sample_tick) overrun <= 1'b1;
        end
        S_SCALE: begin
          acc_r <= acc_r + scaled_s;
          if (voice_r == VIDX_W'(N_VOICES - 1)) begin
            state_r <= S_DONE;
          end else begin
            voice_r <= voice_r + VIDX_W'(1'b1);
            state_r <= S_LOAD;
          end
          if (sample_tick) overrun <= 1'b1;
        end
        S_DONE: begin
          out_sample <= sat16(acc_r);
          out_valid  <= 1'b1;
          // A tick landing on DONE starts the next frame back-to-back
          if (sample_tick) begin
            voice_r <= '0;
            acc_r   <= '0;
            state_r <= S_LOAD;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer_tdm.sv
// Self-checking bench for voice_mixer_tdm: directed scenarios plus randomized frames against a behavioural mix model.
module tb_voice_mixer_tdm;
  localparam int N   = 8;
  localparam int PW  = 24;
  localparam int VW  = 8;
  localparam int OW  = 16;
  localparam int LAT = 3 * N + 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   sample_tick = 1'b0;
  logic [N*PW-1:0]        phase_inc = '0;
  logic [N*2-1:0]         wave_sel = '0;
  logic [N*VW-1:0]        volume = '0;
  logic signed [OW-1:0]   out_sample;
  logic                   out_valid;
  logic                   busy;
  logic                   overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned inc_a [N];
  int          sel_a [N];
  int          vol_a [N];
  longint      m_phase [N];
  int          m_lfsr;

  voice_mixer_tdm #(.N_VOICES(N), .PHASE_W(PW), .VOL_W(VW), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .phase_inc(phase_inc),
    .wave_sel(wave_sel), .volume(volume), .out_sample(out_sample),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      phase_inc[i*PW +: PW] = PW'(inc_a[i]);
      wave_sel[i*2 +: 2]    = 2'(sel_a[i]);
      volume[i*VW +: VW]    = VW'(vol_a[i]);
    end
  endtask

  task automatic set_all(input int unsigned inc, input int sel, input int vol);
    for (int i = 0; i < N; i++) begin
      inc_a[i] = inc; sel_a[i] = sel; vol_a[i] = vol;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_phase[i] = 0;
    m_lfsr = 32'h0000ACE1;
  endtask

  // Reference: evaluate one whole frame from the current per-voice settings
  task automatic model_frame(output int exp);
    longint sum;
    int p, w;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      p = int'(m_phase[i] >> (PW - 16));
      case (sel_a[i])
        0: w = (p >= 32768) ? -32768 : 32767;
        1: w = p - 32768;
        2: w = (p < 32768) ? 2 * p - 32768 : 2 * (65535 - p) - 32768;
        default: begin
`ifdef VOICE_MIXER_NOISE_EN
          w = (m_lfsr >= 32768) ? m_lfsr - 65536 : m_lfsr;
          m_lfsr = (m_lfsr >> 1) | (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
`else
          w = 0;
`endif
        end
      endcase
      sum += (longint'(w) * longint'(vol_a[i])) >>> 8;
      m_phase[i] = (m_phase[i] + longint'(inc_a[i])) & ((longint'(1) << PW) - 1);
    end
    if (sum > 32767) exp = 32767;
    else if (sum < -32768) exp = -32768;
    else exp = int'(sum);
  endtask

  // One tick, then wait (bounded) for out_valid; lat = edges counted from the tick edge
  task automatic do_frame(output int lat, output int res);
    int n;
    lat = -1;
    drive_inputs();
    @(negedge clk); sample_tick = 1'b1;
    @(posedge clk); #1; sample_tick = 1'b0; n = 1;
    while (n < 3 * LAT && out_valid !== 1'b1) begin
      @(posedge clk); #1; n++;
    end
    if (out_valid === 1'b1) lat = n;
    res = int'(out_sample);
  endtask

  task automatic test_reset_state();
    n_checks++; if (out_sample !== 16'sd0) begin n_fail++; $display("FAIL reset_out_sample: got %0d want 0", out_sample); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_square();
    int tab [4] = '{32639, 32639, -32640, -32640};
    int lat, res, e;
    set_all(0, 0, 0);
    inc_a[0] = 32'd1 << 22; vol_a[0] = 255;
    for (int f = 0; f < 8; f++) begin
      model_frame(e);
      do_frame(lat, res);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL square_latency[%0d]: got %0d want %0d", f, lat, LAT); end
      n_checks++; if (res !== tab[f % 4]) begin n_fail++; $display("FAIL square_value[%0d]: got %0d want %0d", f, res, tab[f % 4]); end
      repeat (40 - LAT) @(posedge clk);
    end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL square_no_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_saturation();
    int lat, res, e;
    set_all(0, 0, 255);
    model_frame(e);
    do_frame(lat, res);
    n_checks++; if (res !== 32767) begin n_fail++; $display("FAIL sat_positive: got %0d want 32767", res); end
    set_all(0, 1, 255);
    model_frame(e);
    do_frame(lat, res);
    n_checks++; if (res !== -32768) begin n_fail++; $display("FAIL sat_negative: got %0d want -32768", res); end
  endtask

  task automatic test_shapes();
    int lat, res, e, prev, hi, lo, wraps;
    set_all(0, 0, 0);
    inc_a[0] = 32'd1 << 20; vol_a[0] = 255; sel_a[0] = 2;
    hi = -100000; lo = 100000;
    for (int f = 0; f < 16; f++) begin
      model_frame(e);
      do_frame(lat, res);
      n_checks++; if (res !== e) begin n_fail++; $display("FAIL triangle[%0d]: got %0d want %0d", f, res, e); end
      if (res > hi) hi = res;
      if (res < lo) lo = res;
    end
    n_checks++; if (hi !== (32766 * 255) >>> 8) begin n_fail++; $display("FAIL triangle_peak: got %0d want %0d", hi, (32766 * 255) >>> 8); end
    n_checks++; if (lo !== -32640) begin n_fail++; $display("FAIL triangle_trough: got %0d want -32640", lo); end
    sel_a[0] = 1; wraps = 0; prev = 0;
    for (int f = 0; f < 17; f++) begin
      model_frame(e);
      do_frame(lat, res);
      n_checks++; if (res !== e) begin n_fail++; $display("FAIL saw[%0d]: got %0d want %0d", f, res, e); end
      if (f > 0 && res < prev) wraps++;
      prev = res;
    end
    n_checks++; if (wraps !== 1) begin n_fail++; $display("FAIL saw_wraps: got %0d want 1", wraps); end
  endtask

  task automatic test_random();
    int lat, res, e;
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < N; i++) begin
        inc_a[i] = $urandom & 32'h00FF_FFFF;
        sel_a[i] = int'($urandom_range(0, 3));
        vol_a[i] = int'($urandom_range(0, 255));
      end
      model_frame(e);
      do_frame(lat, res);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d want %0d", f, lat, LAT); end
      n_checks++; if (res !== e) begin n_fail++; $display("FAIL random_value[%0d]: got %0d want %0d", f, res, e); end
    end
  endtask

  task automatic test_overrun();
    int n, lat, res, e, extra;
    for (int i = 0; i < N; i++) begin
      inc_a[i] = $urandom & 32'h00FF_FFFF; sel_a[i] = i % 3; vol_a[i] = 100 + 10 * i;
    end
    drive_inputs();
    model_frame(e);
    lat = -1;
    @(negedge clk); sample_tick = 1'b1;
    @(posedge clk); #1; sample_tick = 1'b0; n = 1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL overrun_busy: got %b want 1", busy); end
    while (n < 3 * LAT && out_valid !== 1'b1) begin
      @(posedge clk); #1; n++;
      sample_tick = (n == 5) ? 1'b1 : 1'b0;
    end
    if (out_valid === 1'b1) lat = n;
    res = int'(out_sample);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL overrun_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (res !== e) begin n_fail++; $display("FAIL overrun_value: got %0d want %0d", res, e); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL overrun_single_valid: got %0d extra pulses want 0", extra); end
    model_frame(e);
    do_frame(lat, res);
    n_checks++; if (res !== e) begin n_fail++; $display("FAIL overrun_next_value: got %0d want %0d", res, e); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset();
    int n, lat, res, e, stray;
    int tab [3] = '{32639, 32639, -32640};
    set_all(0, 0, 0);
    inc_a[0] = 32'd1 << 22; vol_a[0] = 255;
    drive_inputs();
    @(negedge clk); sample_tick = 1'b1;
    @(posedge clk); #1; sample_tick = 1'b0; n = 1;
    while (n < 10) begin @(posedge clk); #1; n++; end
    n_checks++; if (busy !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL prereset_state: got busy=%b overrun=%b want 1 1", busy, overrun); end
    #2; reset = 1'b1; #1;
    n_checks++; if (out_sample !== 16'sd0) begin n_fail++; $display("FAIL midreset_out_sample: got %0d want 0", out_sample); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_overrun: got %b want 0", overrun); end
    model_reset();
    @(negedge clk); @(negedge clk); reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL reset_abandoned_frame: got %0d pulses want 0", stray); end
    for (int f = 0; f < 3; f++) begin
      model_frame(e);
      do_frame(lat, res);
      n_checks++; if (res !== tab[f]) begin n_fail++; $display("FAIL reset_phase0[%0d]: got %0d want %0d", f, res, tab[f]); end
    end
  endtask

  task automatic test_noise();
    int lat, res, e, first;
`ifdef VOICE_MIXER_NOISE_EN
    first = (int'($signed(16'hACE1)) * 255) >>> 8;
`else
    first = 0;
`endif
    set_all(0, 0, 0);
    sel_a[0] = 3; vol_a[0] = 255; inc_a[0] = 32'd12345;
    for (int f = 0; f < 4; f++) begin
      model_frame(e);
      do_frame(lat, res);
      if (f == 0) begin
        n_checks++; if (res !== first) begin n_fail++; $display("FAIL noise_first: got %0d want %0d", res, first); end
      end
      n_checks++; if (res !== e) begin n_fail++; $display("FAIL noise[%0d]: got %0d want %0d", f, res, e); end
    end
  endtask

  initial begin
    set_all(0, 0, 0);
    model_reset();
    drive_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset_state();
    @(negedge clk); reset = 1'b0;
    test_square();
    test_saturation();
    test_shapes();
    test_random();
    test_overrun();
    test_reset();
    test_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
